sdram_cpu_port: RTL

- Upstream front end for the SDRAM controller. It converts the CPU-side single-cycle request/acknowledge bus into the controller's level-held rd/rd_rdy and we/we_rdy handshakes.
- Writes are posted into a small FIFO and acknowledged immediately.
- Reads wait until the FIFO has drained, which guarantees read-after-write coherency.
- Sits between the CPU bus mux and the SDRAM controller, in the same clk domain.

---
 rtl/sdram_port_pkg.sv | 28 ++
 rtl/sdram_wfifo.sv | 46 ++++
 rtl/sdram_cpu_port.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/sdram_port_pkg.sv
// rtl/sdram_port_pkg.sv - shared types for the SDRAM CPU port: FSM states and posted-write entry.
package sdram_port_pkg;

    localparam int FIFO_DEPTH_DEF = 4;
    localparam int ENTRY_AW       = 25;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ISSUE,
        W_BUSY,
        W_DONE
    } wstate_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_DRAIN,
        R_ISSUE,
        R_BUSY
    } rstate_t;

    // 25 + 32 + 4 = 61 bits
    typedef struct packed {
        logic [ENTRY_AW-1:0] addr;
        logic [31:0]         data;
        logic [3:0]          be;
    } wentry_t;

endpackage

// File: rtl/sdram_wfifo.sv
// rtl/sdram_wfifo.sv - posted-write FIFO; head entry is visible combinationally from registered storage.
module sdram_wfifo
    import sdram_port_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic    i_clk,
    input  logic    i_reset,
    input  logic    i_push,
    input  wentry_t i_din,
    input  logic    i_pop,
    output wentry_t o_head,
    output logic    o_full,
    output logic    o_empty
);

    localparam int PW = $clog2(DEPTH);

    wentry_t     r_mem [DEPTH];
    logic [PW:0] r_wptr;
    logic [PW:0] r_rptr;
    logic        w_do_push;
    logic        w_do_pop;

    // Extra MSB on each pointer separates the full case from the empty case.
    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = r_mem[r_rptr[PW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + (PW+1)'(1);
            if (w_do_pop)  r_rptr <= r_rptr + (PW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wptr[PW-1:0]] <= i_din;
    end

endmodule

// File: rtl/sdram_cpu_port.sv
// rtl/sdram_cpu_port.sv - CPU request/ack bus to SDRAM controller rd/we level handshakes.
module sdram_cpu_port
    import sdram_port_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int AW         = ENTRY_AW
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_cpu_req,
    input  logic          i_cpu_we,
    input  logic [AW-1:0] i_cpu_addr,
    input  logic [31:0]   i_cpu_wdata,
    input  logic [3:0]    i_cpu_be,
    output logic          o_cpu_busy,
    output logic          o_cpu_ack,
    output logic [31:0]   o_cpu_rdata,
    output logic [AW-1:0] o_sd_raddr,
    output logic          o_sd_rd,
    input  logic          i_sd_rd_rdy,
    input  logic [31:0]   i_sd_dout,
    output logic [AW-1:0] o_sd_waddr,
    output logic [31:0]   o_sd_din,
    output logic [3:0]    o_sd_be,
    output logic          o_sd_we,
    input  logic          i_sd_we_rdy
);

    wstate_t       r_wstate;
    rstate_t       r_rstate;
    logic          r_sd_we;
    logic          r_sd_rd;
    logic          r_ack;
    logic [31:0]   r_rdata;
    logic [AW-1:0] r_raddr;
    logic [AW-1:0] r_waddr;
    logic [31:0]   r_din;
    logic [3:0]    r_be;

    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic          w_accept;
    logic          w_wr_accept;
    logic          w_rd_accept;
    logic          w_pop;
    logic [AW-1:0] w_addr_even;
    wentry_t       w_push_entry;
    wentry_t       w_head;

    assign o_cpu_busy  = w_fifo_full || (r_rstate != R_IDLE);
    assign w_accept    = i_cpu_req && !o_cpu_busy;
    assign w_wr_accept = w_accept && i_cpu_we;
    assign w_rd_accept = w_accept && !i_cpu_we;
    assign w_addr_even = i_cpu_addr & ~AW'(1);
    assign w_pop       = (r_wstate == W_BUSY) && i_sd_we_rdy;

    assign w_push_entry.addr = ENTRY_AW'(w_addr_even);
    assign w_push_entry.data = i_cpu_wdata;
    assign w_push_entry.be   = i_cpu_be;

    sdram_wfifo #(.DEPTH(FIFO_DEPTH)) u_wfifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_wr_accept),
        .i_din   (w_push_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Write drain: W_DONE guarantees a low cycle on sd_we between accesses.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wstate <= W_IDLE;
            r_sd_we  <= 1'b0;
            r_waddr  <= '0;
            r_din    <= '0;
            r_be     <= '0;
        end else begin
            case (r_wstate)
                W_IDLE: if (!w_fifo_empty && r_rstate != R_BUSY) begin
                    r_waddr  <= AW'(w_head.addr);
                    r_din    <= w_head.data;
                    r_be     <= w_head.be;
                    r_sd_we  <= 1'b1;
                    r_wstate <= W_ISSUE;
                end
                W_ISSUE: if (!i_sd_we_rdy) r_wstate <= W_BUSY;
                W_BUSY: if (i_sd_we_rdy) begin
                    r_sd_we  <= 1'b0;
                    r_wstate <= W_DONE;
                end
                W_DONE: r_wstate <= W_IDLE;
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // Reads wait for the FIFO and write FSM to go quiet, giving read-after-write coherency.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rstate <= R_IDLE;
            r_sd_rd  <= 1'b0;
            r_raddr  <= '0;
            r_rdata  <= '0;
            r_ack    <= 1'b0;
        end else begin
            r_ack <= w_wr_accept;
            case (r_rstate)
                R_IDLE: if (w_rd_accept) begin
                    r_raddr  <= w_addr_even;
                    r_rstate <= R_DRAIN;
                end
                R_DRAIN: if (w_fifo_empty && r_wstate == W_IDLE) begin
                    r_sd_rd  <= 1'b1;
                    r_rstate <= R_ISSUE;
                end
                R_ISSUE: if (!i_sd_rd_rdy) r_rstate <= R_BUSY;
                R_BUSY: if (i_sd_rd_rdy) begin
                    r_sd_rd  <= 1'b0;
                    r_rdata  <= i_sd_dout;
                    r_ack    <= 1'b1;
                    r_rstate <= R_IDLE;
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign o_cpu_ack   = r_ack;
    assign o_cpu_rdata = r_rdata;
    assign o_sd_raddr  = r_raddr;
    assign o_sd_rd     = r_sd_rd;
    assign o_sd_waddr  = r_waddr;
    assign o_sd_din    = r_din;
    assign o_sd_be     = r_be;
    assign o_sd_we     = r_sd_we;

endmodule
